// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: takes one load or store from EXU per handshake, issues a
// single-cycle strobe on the data-memory port and returns the extended load
// data (or a store acknowledgement / error flag) on the response handshake.
//
//   state | meaning
//   IDLE  | ready for a request; decode and latch on in_valid_i
//   ISSUE | one cycle with mem_ren_o or mem_wen_o high
//   RESP  | out_valid_o high; hold outputs until out_ready_i
module ysyx_23060201_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_is_store_i,
  input  logic [2:0]            in_funct3_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [DATA_WIDTH-1:0] in_wdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_rdata_o,
  output logic                  out_misalign_o,
  output logic                  out_illegal_o,
  output logic                  mem_ren_o,
  output logic                  mem_wen_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [7:0]            mem_rmask_o,
  output logic [7:0]            mem_wmask_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ISSUE = 2'b01;
  localparam logic [1:0] S_RESP  = 2'b10;

  logic [1:0]            state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  misalign_q, misalign_d;
  logic                  illegal_q, illegal_d;

  logic                  req_illegal;
  logic                  req_misalign;
  logic [3:0]            lane_mask;
  logic [DATA_WIDTH-1:0] load_shifted;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [ADDR_WIDTH-1:0] word_addr;

  // Decode the incoming request; illegal funct3 outranks misalignment.
  always_comb begin
    req_illegal  = 1'b0;
    req_misalign = 1'b0;
    if (in_is_store_i) begin
      req_illegal = (in_funct3_i[2] == 1'b1) || (in_funct3_i[1:0] == 2'b11);
    end else begin
      req_illegal = !((in_funct3_i == 3'b000) || (in_funct3_i == 3'b001) ||
                      (in_funct3_i == 3'b010) || (in_funct3_i == 3'b100) ||
                      (in_funct3_i == 3'b101));
    end
    if (in_funct3_i[1:0] == 2'b01) begin
      req_misalign = in_addr_i[0];
    end else if (in_funct3_i[1:0] == 2'b10) begin
      req_misalign = (in_addr_i[1:0] != 2'b00);
    end
  end

  // Byte-lane mask and load extraction from the latched request.
  always_comb begin
    lane_mask = 4'b1111;
    case (funct3_q[1:0])
      2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
      2'b01:   lane_mask = 4'b0011 << addr_q[1:0];
      default: lane_mask = 4'b1111;
    endcase
    word_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    load_shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b100:  load_ext = {24'h0, load_shifted[7:0]};
      3'b101:  load_ext = {16'h0, load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

  // Next-state and datapath register update.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    illegal_d  = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          is_store_d = in_is_store_i;
          funct3_d   = in_funct3_i;
          addr_d     = in_addr_i;
          wdata_d    = in_wdata_i;
          rdata_d    = '0;
          illegal_d  = req_illegal;
          misalign_d = !req_illegal && req_misalign;
          state_d    = (req_illegal || req_misalign) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // mem_rdata_i is only valid in this cycle, so it is extended and kept now.
        if (!is_store_q) begin
          rdata_d = load_ext;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      illegal_q  <= illegal_d;
    end
  end

  // Output decode: memory port only live in ISSUE, response only in RESP.
  always_comb begin
    in_ready_o     = (state_q == S_IDLE);
    out_valid_o    = 1'b0;
    out_rdata_o    = '0;
    out_misalign_o = 1'b0;
    out_illegal_o  = 1'b0;
    mem_ren_o      = 1'b0;
    mem_wen_o      = 1'b0;
    mem_raddr_o    = '0;
    mem_waddr_o    = '0;
    mem_rmask_o    = 8'h00;
    mem_wmask_o    = 8'h00;
    mem_wdata_o    = '0;
    if (state_q == S_ISSUE) begin
      if (is_store_q) begin
        mem_wen_o   = 1'b1;
        mem_waddr_o = word_addr;
        mem_wmask_o = {4'b0000, lane_mask};
        mem_wdata_o = wdata_q << {addr_q[1:0], 3'b000};
      end else begin
        mem_ren_o   = 1'b1;
        mem_raddr_o = word_addr;
        mem_rmask_o = {4'b0000, lane_mask};
      end
    end
    if (state_q == S_RESP) begin
      out_valid_o    = 1'b1;
      out_rdata_o    = rdata_q;
      out_misalign_o = misalign_q;
      out_illegal_o  = illegal_q;
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Bench for the LSU: a word-wide memory responder plus a byte-addressed
// reference memory; loads, stores and error requests are checked against it.
module tb_ysyx_23060201_lsu;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready;
  logic [31:0] out_rdata;
  logic        out_misalign, out_illegal;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [7:0]  mem_rmask, mem_wmask;

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_total = 0;
  logic prev_strobe = 1'b0;

  logic [31:0] mem_w [16];
  logic [7:0]  ref_mem [64];
  logic        init_we = 1'b0;
  logic [3:0]  init_idx = 4'd0;
  logic [31:0] init_val = 32'h0;

  always #5 clk = ~clk;

  ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_is_store_i(in_is_store),
    .in_funct3_i(in_funct3), .in_addr_i(in_addr), .in_wdata_i(in_wdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_rdata_o(out_rdata),
    .out_misalign_o(out_misalign), .out_illegal_o(out_illegal),
    .mem_ren_o(mem_ren), .mem_wen_o(mem_wen),
    .mem_raddr_o(mem_raddr), .mem_waddr_o(mem_waddr),
    .mem_rmask_o(mem_rmask), .mem_wmask_o(mem_wmask),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Memory responder: combinational read in the strobe cycle, masked write on the edge.
  assign mem_rdata = mem_ren ? mem_w[mem_raddr[5:2]] : 32'h0;

  always @(posedge clk) begin
    logic [31:0] nw;
    if (init_we) begin
      mem_w[init_idx] <= init_val;
    end else if (mem_wen) begin
      nw = mem_w[mem_waddr[5:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) nw[8*b +: 8] = mem_wdata[8*b +: 8];
      mem_w[mem_waddr[5:2]] <= nw;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Port-level invariants checked every cycle.
  always @(negedge clk) begin
    chk("no_back_to_back_strobe", 32'((mem_ren | mem_wen) & prev_strobe), 32'h0);
    if (!mem_ren) chk("rside_zero_off_strobe", mem_raddr | 32'(mem_rmask), 32'h0);
    if (!mem_wen) chk("wside_zero_off_strobe", mem_waddr | mem_wdata | 32'(mem_wmask), 32'h0);
    strobe_total = strobe_total + 32'(mem_ren) + 32'(mem_wen);
    prev_strobe  = mem_ren | mem_wen;
  end

  task automatic set_word(input int idx, input logic [31:0] val);
    @(negedge clk);
    init_we = 1'b1; init_idx = 4'(idx); init_val = val;
    for (int k = 0; k < 4; k++) ref_mem[4*idx + k] = val[8*k +: 8];
    @(negedge clk);
    init_we = 1'b0;
  endtask

  function automatic int access_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off);
    int n;
    logic [31:0] v;
    n = access_bytes(f3);
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[off + k]) << (8 * k));
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic txn(input logic st, input logic [2:0] f3, input int off,
                     input logic [31:0] wd, input int bp);
    int n, start;
    logic ill, mis, legal;
    logic [31:0] exp_rd, addr;
    n     = access_bytes(f3);
    addr  = BASE + 32'(off);
    ill   = st ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis   = !ill && ((off % n) != 0);
    legal = !ill && !mis;
    exp_rd = (st || !legal) ? 32'h0 : model_load(f3, off);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'h1);
    start = strobe_total;
    in_valid = 1'b1; in_is_store = st; in_funct3 = f3; in_addr = addr; in_wdata = wd;
    @(negedge clk);
    in_valid = 1'($urandom_range(0, 1));
    in_is_store = 1'($urandom_range(0, 1));
    in_funct3 = 3'($urandom_range(0, 7));
    in_addr = BASE + 32'($urandom_range(0, 63));
    in_wdata = $urandom;
    chk("in_ready_busy", 32'(in_ready), 32'h0);
    if (!legal) begin
      chk("err_out_valid_n1", 32'(out_valid), 32'h1);
    end else begin
      chk("out_valid_low_in_issue", 32'(out_valid), 32'h0);
      chk("mem_ren", 32'(mem_ren), 32'(!st));
      chk("mem_wen", 32'(mem_wen), 32'(st));
      if (st) begin
        chk("mem_waddr", mem_waddr, addr & 32'hFFFF_FFFC);
        chk("mem_wmask", 32'(mem_wmask), 32'(((1 << n) - 1) << (off % 4)));
        chk("mem_wdata", mem_wdata, wd << (8 * (off % 4)));
      end else begin
        chk("mem_raddr", mem_raddr, addr & 32'hFFFF_FFFC);
        chk("mem_rmask", 32'(mem_rmask), 32'(((1 << n) - 1) << (off % 4)));
      end
      @(negedge clk);
      chk("out_valid_n2", 32'(out_valid), 32'h1);
    end
    chk("out_illegal", 32'(out_illegal), 32'(ill));
    chk("out_misalign", 32'(out_misalign), 32'(mis));
    chk("out_rdata", out_rdata, exp_rd);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_rdata", out_rdata, exp_rd);
      chk("hold_flags", 32'({out_illegal, out_misalign}), 32'({ill, mis}));
      chk("hold_in_ready", 32'(in_ready), 32'h0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop_after_hs", 32'(out_valid), 32'h0);
    chk("in_ready_after_hs", 32'(in_ready), 32'h1);
    chk("strobe_count", 32'(strobe_total - start), 32'(legal));
    if (st && legal)
      for (int k = 0; k < n; k++) ref_mem[off + k] = wd[8*k +: 8];
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int off;
    logic [2:0] f3;
    logic [31:0] wd;
    rst = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_funct3 = 3'd0;
    in_addr = 32'h0; in_wdata = 32'h0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      chk("rst_strobes", 32'({mem_ren, mem_wen}), 32'h0);
      chk("rst_out", 32'({out_valid, out_misalign, out_illegal}) | out_rdata, 32'h0);
    end

    // Directed cases.
    set_word(1, 32'hDEAD_BEEF);
    txn(1'b0, 3'b010, 4, 32'h0, 0);
    chk("lw_value_model", model_load(3'b010, 4), 32'hDEAD_BEEF);
    set_word(0, 32'h80FF_0000);
    txn(1'b0, 3'b000, 3, 32'h0, 0);
    chk("lb_value_model", model_load(3'b000, 3), 32'hFFFF_FF80);
    txn(1'b0, 3'b100, 3, 32'h0, 0);
    txn(1'b1, 3'b001, 2, 32'h1234_ABCD, 0);
    txn(1'b0, 3'b101, 2, 32'h0, 1);
    txn(1'b0, 3'b001, 1, 32'h0, 0);
    txn(1'b0, 3'b011, 0, 32'h0, 0);
    txn(1'b1, 3'b100, 0, 32'h0, 0);
    txn(1'b0, 3'b010, 8, 32'h0, 5);

    // Reset while a store is in ISSUE: one write cycle, then idle.
    wd = 32'hA5C3_1E77;
    @(negedge clk);
    in_valid = 1'b1; in_is_store = 1'b1; in_funct3 = 3'b010; in_addr = BASE + 32'd12; in_wdata = wd;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_issue_wen", 32'(mem_wen), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) ref_mem[12 + k] = wd[8*k +: 8];
    chk("rst_issue_wen_off", 32'(mem_wen), 32'h0);
    chk("rst_issue_idle", 32'(in_ready), 32'h1);
    chk("rst_issue_no_resp", 32'(out_valid), 32'h0);
    txn(1'b0, 3'b010, 12, 32'h0, 0);

    // Reset while a response is pending: response dropped.
    @(negedge clk);
    in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b011; in_addr = BASE;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_resp_valid_before", 32'(out_valid), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_resp_dropped", 32'(out_valid), 32'h0);
    chk("rst_resp_flag_clr", 32'(out_illegal), 32'h0);

    // Randomized traffic against the byte-level model.
    for (int t = 0; t < 300; t++) begin
      off = $urandom_range(0, 63);
      f3  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0 && f3[1:0] != 2'b00) off = off & ~((1 << f3[1:0]) - 1) & 63;
      txn(1'($urandom_range(0, 1)), f3, off, $urandom, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
